ss_piso_serializer: RTL and testbench



---
 rtl/ss_pkg.sv | 26 ++
 rtl/ss_bit_timer.sv | 37 +++
 rtl/ss_piso_serializer.sv | 122 ++++++++++++
 tb/tb_ss_piso_serializer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared definitions for the serial-register feeder family: FSM state
// encoding, the default word width and a width helper for counters.
package ss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ss_state_e;

    localparam int SS_WIDTH_DEFAULT = 8;

    // Bits needed to count 0..value-1, never less than one bit so that
    // degenerate counters (value == 1) still have a legal declaration.
    function automatic int ss_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ss_bit_timer.sv
// Bit-period timer: counts enabled clocks and raises a one-cycle strobe in
// the last clock of every DIV-clock period. Shared with the deserializer.
module ss_bit_timer
    import ss_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ena,
    input  logic i_clear,
    output logic o_strobe
);

    localparam int            CW   = ss_clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_div_cnt;

    // Strobe is combinational from the registered count, gated by enable so
    // a frozen period never emits a sample pulse.
    assign o_strobe = i_ena & (r_div_cnt == LAST);

    // Period counter: restart on clear or at the end of each period, hold when disabled.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (i_clear || o_strobe) begin
            r_div_cnt <= '0;
        end else if (i_ena) begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ss_piso_serializer.sv
// Parallel-in/serial-out feeder for the serial register. Accepts a word on
// a valid/ready handshake, shifts it out one bit per DIV clocks with a
// sample strobe, then pulses done for one cycle before returning to idle.
module ss_piso_serializer
    import ss_pkg::*;
#(
    parameter int WIDTH     = SS_WIDTH_DEFAULT,
    parameter bit LSB_FIRST = 1'b0,
    parameter int DIV       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_strobe,
    output logic             busy,
    output logic             done
);

    localparam int            BW       = ss_clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    ss_state_e        r_state;
    ss_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_ready_en;

    logic w_accept;
    logic w_shift_en;
    logic w_strobe;
    logic w_last_bit;
    logic w_ser_bit;

    assign w_shift_en = ena & (r_state == SHIFT);
    assign w_accept   = din_valid & din_ready;
    assign w_last_bit = (r_bit_cnt == LAST_BIT);
    assign w_ser_bit  = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];

    ss_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_ena    (w_shift_en),
        .i_clear  (w_accept),
        .o_strobe (w_strobe)
    );

    // Keeps din_ready low during reset and until the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // FSM state register; ena low freezes the machine through the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, leave SHIFT on the last bit's strobe,
    // leave DONE only on an enabled clock so a frozen DONE still pulses later.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and
        // no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)              w_state_nxt = SHIFT;
            SHIFT:   if (w_strobe && w_last_bit) w_state_nxt = DONE;
            DONE:    if (ena)                   w_state_nxt = IDLE;
            default:                            w_state_nxt = IDLE;
        endcase
    end

    // Shift datapath: load on accept, shift toward the output end with zero fill on each strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_shreg   <= din;
            r_bit_cnt <= '0;
        end else if (w_strobe) begin
            r_shreg <= LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
            if (!w_last_bit) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
        end
    end

    // Output decode from registered state; ser_out is forced low outside SHIFT.
    always_comb begin
        din_ready  = 1'b0;
        ser_out    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        ser_strobe = w_strobe;
        case (r_state)
            IDLE:  din_ready = ena & r_ready_en;
            SHIFT: begin
                ser_out = w_ser_bit;
                busy    = 1'b1;
            end
            DONE: begin
                done = ena;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ss_piso_serializer.sv
// Self-checking bench for ss_piso_serializer. Two instances cover MSB-first
// DIV=1 and LSB-first DIV=4; a shared driver is steered to one at a time.
// Expected bits, strobe timing and handshake timing come from a small
// cycle-count model built from the word, bit order and divider.
module tb_ss_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         sel;
    logic         drv_valid;
    logic [W-1:0] drv_din;

    logic a_valid, a_ready, a_ser, a_stb, a_busy, a_done;
    logic b_valid, b_ready, b_ser, b_stb, b_busy, b_done;
    logic m_ready, m_ser, m_stb, m_busy, m_done;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    assign a_valid = drv_valid & ~sel;
    assign b_valid = drv_valid & sel;
    assign m_ready = sel ? b_ready : a_ready;
    assign m_ser   = sel ? b_ser   : a_ser;
    assign m_stb   = sel ? b_stb   : a_stb;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;

    ss_piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .DIV(1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .din        (drv_din),
        .din_valid  (a_valid),
        .din_ready  (a_ready),
        .ser_out    (a_ser),
        .ser_strobe (a_stb),
        .busy       (a_busy),
        .done       (a_done)
    );

    ss_piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .DIV(4)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .din        (drv_din),
        .din_valid  (b_valid),
        .din_ready  (b_ready),
        .ser_out    (b_ser),
        .ser_strobe (b_stb),
        .busy       (b_busy),
        .done       (b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit number idx of the serial stream for a given word and bit order.
    function automatic logic model_bit(input logic [W-1:0] word, input int idx, input bit lsb);
        int pos;
        pos = lsb ? idx : (W - 1 - idx);
        return ((word >> pos) & 1) != 0;
    endfunction

    // Send one word through the selected instance and check every cycle of it.
    // k counts enabled clocks after the accepting edge: bits occupy k < W*div,
    // done at k == W*div, ready again at k == W*div+1. Paused clocks do not
    // advance k. abort_k >= 0 asserts reset between edges at that cycle.
    task automatic xfer(input logic [W-1:0] word, input bit hold_valid,
                        input logic [W-1:0] next_din, input int pause_after,
                        input int pause_len, input int abort_k, input bit expect_now);
        int   dv, total, k, nstb, plen, waited, seen;
        bit   lsb, exp_stb;
        logic expb;
        dv    = sel ? 4 : 1;
        lsb   = sel;
        total = W * dv;
        drv_din   = word;
        drv_valid = 1'b1;
        ena       = 1'b1;
        #1;
        waited = 0;
        while (!m_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!m_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            drv_valid = 1'b0;
            return;
        end
        if (expect_now) check("accept_immediate", waited, 32'd0);
        @(posedge clk); #1;
        drv_valid = hold_valid;
        if (hold_valid) drv_din = next_din;
        k    = 0;
        nstb = 0;
        plen = pause_len;
        seen = 0;
        while (k <= total + 1) begin
            expb = (k < total) ? model_bit(word, k / dv, lsb) : 1'b0;
            if (nstb == pause_after && plen > 0) begin
                ena = 1'b0;
                #1;
                check("frz_strobe", m_stb, 32'd0);
                check("frz_done", m_done, 32'd0);
                check("frz_ready", m_ready, 32'd0);
                check("frz_busy", m_busy, 32'd1);
                check("frz_ser_out", m_ser, expb);
                plen--;
            end else begin
                ena = 1'b1;
                #1;
                exp_stb = (k < total) && ((k % dv) == dv - 1);
                check("ser_out", m_ser, expb);
                check("strobe", m_stb, exp_stb);
                check("done", m_done, k == total);
                check("busy", m_busy, k <= total);
                check("ready", m_ready, k == total + 1);
                if (m_stb === 1'b1) seen++;
                if (exp_stb) nstb++;
                if (k == abort_k) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check("rst_busy", m_busy, 32'd0);
                    check("rst_ser_out", m_ser, 32'd0);
                    check("rst_strobe", m_stb, 32'd0);
                    check("rst_ready", m_ready, 32'd0);
                    repeat (2) begin
                        @(posedge clk); #1;
                        check("rst_hold_done", m_done, 32'd0);
                        check("rst_hold_busy", m_busy, 32'd0);
                        check("rst_hold_ready", m_ready, 32'd0);
                    end
                    #2 rst_n = 1'b1;
                    #1;
                    check("rst_release_ready", m_ready, 32'd0);
                    @(posedge clk); #1;
                    check("rst_ready_back", m_ready, 32'd1);
                    check("rst_no_done", m_done, 32'd0);
                    return;
                end
                k++;
            end
            if (k <= total + 1) begin
                @(posedge clk); #1;
            end
        end
        check("strobe_count", seen, W);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] word;
        int pa, pl;
        rst_n     = 1'b0;
        ena       = 1'b1;
        sel       = 1'b0;
        drv_valid = 1'b0;
        drv_din   = '0;

        // Reset and idle behaviour on both instances.
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready_a", a_ready, 32'd0);
        check("reset_ready_b", b_ready, 32'd0);
        check("reset_ser_a", a_ser, 32'd0);
        check("reset_busy_a", a_busy, 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_ready_a", a_ready, 32'd1);
            check("idle_ready_b", b_ready, 32'd1);
            check("idle_ser_a", a_ser, 32'd0);
            check("idle_busy_a", a_busy, 32'd0);
            check("idle_strobe_a", a_stb, 32'd0);
            check("idle_strobe_b", b_stb, 32'd0);
            check("idle_done_b", b_done, 32'd0);
        end

        // MSB-first, one clock per bit.
        sel = 1'b0;
        xfer(8'hA5, 1'b0, 8'h00, -1, 0, -1, 1'b0);

        // LSB-first, four clocks per bit.
        sel = 1'b1;
        xfer(8'h3C, 1'b0, 8'h00, -1, 0, -1, 1'b0);

        // Back-to-back with valid held: second word accepted on first IDLE cycle.
        sel = 1'b0;
        xfer(8'hFF, 1'b1, 8'h00, -1, 0, -1, 1'b0);
        xfer(8'h00, 1'b0, 8'h00, -1, 0, -1, 1'b1);

        // Freeze for five clocks after the third strobe.
        xfer(8'h81, 1'b0, 8'h00, 3, 5, -1, 1'b0);

        // Asynchronous reset mid-word, then a clean word.
        xfer(8'hFF, 1'b0, 8'h00, -1, 0, 4, 1'b0);
        xfer(8'h5A, 1'b0, 8'h00, -1, 0, -1, 1'b0);

        // Freeze inside DONE on the divided instance.
        sel = 1'b1;
        xfer(8'h96, 1'b0, 8'h00, W, 3, -1, 1'b0);

        // Random words, instances and freeze points.
        for (int n = 0; n < 10; n++) begin
            sel  = 1'($urandom_range(0, 1));
            word = W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                pa = int'($urandom_range(0, W));
                pl = int'($urandom_range(1, 6));
            end else begin
                pa = -1;
                pl = 0;
            end
            xfer(word, 1'b0, 8'h00, pa, pl, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
